// File: rtl/fifod2mac.sv
// Transmit path: drains a fixed byte count from the device FIFO into the MAC UDP
// tx buffer, then requests a single send and reports completion on fs/fd.
//
// state | meaning
// IDLE  | counters cleared, waiting for fs; length latched on start
// LOAD  | copying FIFO bytes into the MAC buffer
// SEND  | one-cycle send request, length field registered
// WAIT  | waiting for the MAC to report the frame has gone out
// LAST  | fd high until the controller drops fs
module fifod2mac #(
  parameter int MAX_LEN = 1472,
  parameter int HDR_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [11:0] dev_tx_len,
  input  logic [7:0]  fifod_rxd,
  input  logic        fifod_empty,
  output logic        fifod_rxen,
  output logic [7:0]  udp_txd,
  output logic [10:0] udp_tx_addr,
  output logic        udp_txen,
  output logic [15:0] udp_tx_len,
  output logic        udp_tx_start,
  input  logic        udp_tx_done
);

  localparam logic [11:0] MAX_LEN_C = 12'(MAX_LEN);
  localparam logic [15:0] HDR_LEN_C = 16'(HDR_LEN);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    LAST = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] len_q, len_d;
  logic [11:0] rd_cnt_q, rd_cnt_d;
  logic [11:0] wr_cnt_q, wr_cnt_d;
  logic        txen_q, txen_d;
  logic [15:0] tx_len_q, tx_len_d;
  logic [11:0] len_clamp;

  always_comb begin
    len_clamp = dev_tx_len;
    if (dev_tx_len > MAX_LEN_C) len_clamp = MAX_LEN_C;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fs) state_d = (len_clamp == 12'd0) ? LAST : LOAD;
      // wr_cnt reaching len_q means the final byte was written last cycle
      LOAD: if (wr_cnt_q == len_q) state_d = SEND;
      SEND: state_d = WAIT;
      WAIT: if (udp_tx_done) state_d = LAST;
      LAST: if (!fs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifod_rxen   = 1'b0;
    udp_tx_start = 1'b0;
    fd           = 1'b0;
    case (state_q)
      LOAD: fifod_rxen = (rd_cnt_q != len_q) && !fifod_empty;
      SEND: udp_tx_start = 1'b1;
      LAST: fd = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    tx_len_d = tx_len_q;
    // write enable trails the read by one cycle to match FIFO read latency
    txen_d   = fifod_rxen;
    if (state_q == IDLE) begin
      rd_cnt_d = 12'd0;
      wr_cnt_d = 12'd0;
      if (fs) len_d = len_clamp;
    end else begin
      if (fifod_rxen) rd_cnt_d = rd_cnt_q + 12'd1;
      if (txen_q)     wr_cnt_d = wr_cnt_q + 12'd1;
    end
    if (state_q == SEND) tx_len_d = {4'd0, len_q} + HDR_LEN_C;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q    <= 12'd0;
      rd_cnt_q <= 12'd0;
      wr_cnt_q <= 12'd0;
      txen_q   <= 1'b0;
      tx_len_q <= 16'd0;
    end else begin
      len_q    <= len_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      txen_q   <= txen_d;
      tx_len_q <= tx_len_d;
    end
  end

  assign udp_txd     = fifod_rxd;
  assign udp_txen    = txen_q;
  assign udp_tx_addr = wr_cnt_q[10:0];
  assign udp_tx_len  = tx_len_q;

endmodule
